// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the RAM port arbiter.
package ram_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_AW   = 8;
  localparam int DEF_DW   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester command/response bus plus the RAM port, as seen by the arbiter.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) ();

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0]    reqValid;
  logic [NREQ-1:0]    reqReady;
  logic [NREQ-1:0]    reqWrite;
  logic [NREQ*AW-1:0] reqAddr;
  logic [NREQ*DW-1:0] reqWData;
  logic [NREQ-1:0]    rspValid;
  logic [DW-1:0]      rspData;
  logic [IW-1:0]      grantId;
  logic               ramEn;
  logic               ramWrite;
  logic [AW-1:0]      ramAddr;
  logic [DW-1:0]      ramWData;
  logic [DW-1:0]      ramRData;

  // master: requesters plus the RAM model
  modport master (
    output reqValid, reqWrite, reqAddr, reqWData, ramRData,
    input  reqReady, rspValid, rspData, grantId, ramEn, ramWrite, ramAddr, ramWData
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqWData, ramRData,
    output reqReady, rspValid, rspData, grantId, ramEn, ramWrite, ramAddr, ramWData
  );

endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = i_ptr;
    o_any = 1'b0;
    w_c   = i_ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_c = (w_c == IW'(NREQ-1)) ? '0 : w_c + 1'b1;
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters, with read return.
// Define RAM_ARB_BURST_EN to let an owner hold the grant for up to MAXBURST beats.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAXBURST = 4
) (
  input logic              clk,
  input logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam int IW = idx_w(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("ram_port_arbiter: NREQ must be 2..8");
  end
  if (MAXBURST < 1) begin : g_bad_burst
    $error("ram_port_arbiter: MAXBURST must be >= 1");
  end

  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_rdId;
  logic            r_rdPend;

  logic [NREQ-1:0] w_pick_gnt;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic            w_keep;
  logic            w_any;
  logic [NREQ-1:0] w_own_oh;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_ram_write;
  logic [AW-1:0]   w_ram_addr;
  logic [DW-1:0]   w_ram_wdata;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req (bus.reqValid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

`ifdef RAM_ARB_BURST_EN
  localparam int CW = idx_w(MAXBURST + 1);

  arb_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  // r_ptr always holds the last winner, so in OWN it names the owner
  assign w_keep = (r_state == OWN) && bus.reqValid[r_ptr] && (r_cnt < CW'(MAXBURST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // w_keep implies r_cnt < MAXBURST, so the increment cannot wrap
  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_nxt   = '0;
    if (w_any) begin
      w_state_nxt = OWN;
      w_cnt_nxt   = w_keep ? r_cnt + 1'b1 : CW'(1);
    end
  end
`else
  assign w_keep = 1'b0;
`endif

  assign w_own_oh = NREQ'(1) << r_ptr;
  assign w_any    = !rst && (w_keep || w_pick_any);
  assign w_gnt    = w_any ? (w_keep ? w_own_oh : w_pick_gnt) : '0;
  assign w_idx    = w_keep ? r_ptr : w_pick_idx;

  always_comb begin
    w_ram_write = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_ram_write = w_ram_write | bus.reqWrite[i];
        w_ram_addr  = w_ram_addr  | bus.reqAddr[i*AW +: AW];
        w_ram_wdata = w_ram_wdata | bus.reqWData[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= IW'(NREQ-1);
      r_rdPend <= 1'b0;
      r_rdId   <= '0;
    end else begin
      r_rdPend <= w_any && !w_ram_write;
      if (w_any) begin
        r_ptr  <= w_idx;
        r_rdId <= w_idx;
      end
    end
  end

  assign bus.reqReady = w_gnt;
  assign bus.ramEn    = w_any;
  assign bus.ramWrite = w_ram_write;
  assign bus.ramAddr  = w_ram_addr;
  assign bus.ramWData = w_ram_wdata;
  assign bus.grantId  = w_any ? w_idx : r_ptr;
  assign bus.rspValid = r_rdPend ? (NREQ'(1) << r_rdId) : '0;
  assign bus.rspData  = bus.ramRData;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus queues expected grants/responses, a monitor checks them.
module tb_ram_port_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;

`ifdef RAM_ARB_BURST_EN
  localparam int T2G[5] = '{0, 0, 0, 0, 1};
  localparam int T3G[9] = '{0, 0, 0, 0, 2, 2, 2, 2, 0};
  localparam int T4G[3] = '{0, 0, 3};
`else
  localparam int T2G[5] = '{0, 1, 2, 3, 0};
  localparam int T3G[9] = '{0, 2, 0, 2, 0, 2, 0, 2, 0};
  localparam int T4G[3] = '{0, 3, 3};
`endif

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAXBURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model with a side preload path
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ram_rdata;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.ramEn) begin
      if (bus.ramWrite) mem[bus.ramAddr] <= bus.ramWData;
      else ram_rdata <= mem[bus.ramAddr];
    end
  end
  assign bus.ramRData = ram_rdata;

  int   checks = 0;
  int   errors = 0;
  int   exp_g[$];
  rsp_t exp_r[$];
  bit   pend = 1'b0;
  int   last_g = NREQ - 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_rsp(input int id, input logic [DW-1:0] d);
    rsp_t r;
    r.id = id;
    r.data = d;
    exp_r.push_back(r);
  endtask

  task automatic set_cmd(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.reqValid[id]           = 1'b1;
    bus.reqWrite[id]           = wr;
    bus.reqAddr[id*AW +: AW]   = a;
    bus.reqWData[id*DW +: DW]  = d;
  endtask

  // Issue one command and hold it until accepted (bounded wait)
  task automatic cmd(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    set_cmd(id, wr, a, d);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.reqReady[id]) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.reqValid[id] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.reqValid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic flush();
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int   g;
    rsp_t r;
    if (rst) begin
      chk("rst_reqReady", bus.reqReady, 0);
      chk("rst_ramEn", bus.ramEn, 0);
      chk("rst_rspValid", bus.rspValid, 0);
      chk("rst_grantId", bus.grantId, NREQ - 1);
      pend   = 1'b0;
      last_g = NREQ - 1;
    end else begin
      if (pend) begin
        if (exp_r.size() == 0) chk("rsp_unexpected", bus.rspValid, 0);
        else begin
          r = exp_r.pop_front();
          chk("rsp_valid", bus.rspValid, 64'd1 << r.id);
          chk("rsp_data", bus.rspData, r.data);
        end
      end else chk("rsp_idle", bus.rspValid, 0);

      if (bus.reqReady != 0) begin
        if (exp_g.size() == 0) begin
          chk("grant_unexpected", bus.reqReady, 0);
          pend = 1'b0;
        end else begin
          g = exp_g.pop_front();
          chk("grant", bus.reqReady, 64'd1 << g);
          chk("grantId", bus.grantId, g);
          chk("ram_en", bus.ramEn, 1);
          chk("ram_addr", bus.ramAddr, bus.reqAddr[g*AW +: AW]);
          chk("ram_write", bus.ramWrite, bus.reqWrite[g]);
          if (bus.reqWrite[g]) chk("ram_wdata", bus.ramWData, bus.reqWData[g*DW +: DW]);
          pend   = !bus.reqWrite[g];
          last_g = g;
        end
      end else begin
        chk("idle_ramEn", bus.ramEn, 0);
        chk("idle_ramAddr", bus.ramAddr, 0);
        chk("idle_grantId", bus.grantId, last_g);
        pend = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    ld_en        = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;
    bus.reqValid = '0;
    bus.reqWrite = '0;
    bus.reqAddr  = '0;
    bus.reqWData = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      ld_en   = 1'b1;
      ld_addr = AW'(20 + k);
      ld_data = 32'hB000_0014 + DW'(k);
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // single requester: write then read back the same address
    exp_g.push_back(1);
    cmd(1, 1'b1, 8'd5, 32'hA000_0001);
    exp_g.push_back(1);
    push_rsp(1, 32'hA000_0001);
    cmd(1, 1'b0, 8'd5, '0);
    flush();

    // all four requesters valid from reset
    do_reset();
    foreach (T2G[i]) exp_g.push_back(T2G[i]);
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, AW'(40 + i), 32'hC000_0000 + DW'(i));
    repeat (5) @(posedge clk);
    #1 bus.reqValid = '0;
    flush();

    // req0 and req2 held valid
    do_reset();
    foreach (T3G[i]) exp_g.push_back(T3G[i]);
    set_cmd(0, 1'b1, 8'd50, 32'hD000_0000);
    set_cmd(2, 1'b1, 8'd52, 32'hD000_0002);
    repeat (9) @(posedge clk);
    #1 bus.reqValid = '0;
    flush();

    // req0 drops after two cycles while req3 waits
    do_reset();
    foreach (T4G[i]) exp_g.push_back(T4G[i]);
    set_cmd(0, 1'b1, 8'd60, 32'hE000_0000);
    set_cmd(3, 1'b1, 8'd63, 32'hE000_0003);
    repeat (2) @(posedge clk);
    #1 bus.reqValid[0] = 1'b0;
    @(posedge clk);
    #1 bus.reqValid[3] = 1'b0;
    flush();

    // back-to-back reads by req2 of preloaded addresses 20..23
    for (int k = 0; k < 4; k++) begin
      exp_g.push_back(2);
      push_rsp(2, 32'hB000_0014 + DW'(k));
    end
    for (int k = 0; k < 4; k++) begin
      set_cmd(2, 1'b0, AW'(20 + k), '0);
      @(posedge clk); #1;
    end
    bus.reqValid[2] = 1'b0;
    flush();

    // reset between read acceptance and its response
    exp_g.push_back(1);
    set_cmd(1, 1'b0, 8'd21, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b1, AW'(70 + i), 32'hF000_0000 + DW'(i));
    exp_g.push_back(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 bus.reqValid = '0;
    flush();

    chk("grant_queue_empty", exp_g.size(), 0);
    chk("rsp_queue_empty", exp_r.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one port of the dual-port RAM among NREQ requesters. Each requester presents a valid/ready command (read or write). The arbiter picks one winner per cycle and drives the RAM port. One cycle after a read is accepted, the arbiter routes the RAM read data back to the requester that issued it. It sits between client blocks and port A or B of DualPortRAM; write-write conflicts across the two RAM ports remain the RAM's concern.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 8, RAM address width
- DW, 32, RAM data width
- MAXBURST, 4, max consecutive grants to one owner (burst build only, ≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- reqValid  in  NREQ  command valid per requester
- reqReady  out  NREQ  command accepted this cycle (one-hot or zero)
- reqWrite  in  NREQ  1 = write, 0 = read
- reqAddr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- reqWData  in  NREQ*DW  packed write data
- rspValid  out  NREQ  read data valid for requester i (one-hot or zero)
- rspData  out  DW  read data, shared by all requesters
- grantId  out  $clog2(NREQ)  index of current winner; holds the last winner when idle
- ramEn, ramWrite  out  1  to RAM port enable/write
- ramAddr  out  AW; ramWData  out  DW  to RAM port
- ramRData  in  DW  from RAM port (registered, valid cycle after accepted read)

## Operation
- Handshake: command i transfers on the cycle where reqValid[i] && reqReady[i]. reqReady depends combinationally on reqValid, never the reverse. Requester must hold its command stable until accepted.
- Grant: search starts at ptr+1 modulo NREQ. The first requester with reqValid set wins. ptr is the registered index of the last winner.
- RAM drive: ramEn = |reqReady. ramWrite, ramAddr and ramWData are muxed combinationally from the winner. With no winner, ramEn=0, ramWrite=0, and addr/data are 0.
- Read return: on an accepted read, register rdPend=1 and rdId=winner. The next cycle gives rspValid[rdId]=1 and rspData=ramRData. Writes produce no response.
- Ordering: a read accepted the cycle after a write to the same address returns the new data, since a single port serialises commands.
- State machine (burst build): IDLE → OWN on any grant; load owner=winner and cnt=1.
  - OWN, owner still valid and cnt<MAXBURST: owner wins again; cnt++.
  - OWN, owner drops reqValid or cnt==MAXBURST: ptr=owner and normal RR search this cycle. Go to OWN with a new owner, or to IDLE if no requests.
- cnt width is $clog2(MAXBURST+1). It saturates and never wraps.

## Timing
- Grant latency 0: reqReady in the same cycle as reqValid when winning.
- Read latency 1: rspValid exactly one cycle after acceptance. Back-to-back reads give back-to-back responses at one per cycle.
- Reset values: ptr=NREQ-1 (requester 0 wins first), rdPend=0, state IDLE, cnt=0. Hence rspValid=0 and grantId=NREQ-1.
- While rst is high: reqReady=0 and ramEn=0, forced regardless of reqValid.
- Reset mid-read: the pending response is dropped and rspValid stays 0 after release.
- Simultaneous requests all resolve through the RR pointer; no requester waits more than NREQ-1 grants (×MAXBURST in the burst build).

## Configuration
- RAM_ARB_BURST_EN defined: the IDLE/OWN burst state machine and MAXBURST apply; the owner keeps the grant for up to MAXBURST consecutive accepted commands.
- RAM_ARB_BURST_EN undefined: there is no state machine. ptr advances to the winner after every grant, giving strict one-beat round robin, and MAXBURST is ignored.
- MAXBURST=1 with the macro defined must behave identically to the undefined build.

## Structure
- Package ram_arb_pkg holds:
  - the arb_state_e enum (IDLE, OWN)
  - the default NREQ, AW and DW localparams
  - the function idx_w(n) = $clog2(n) used for ptr, rdId and grantId widths.
- Sub-module rr_pick (combinational): inputs req[NREQ] and ptr; outputs the one-hot gnt and its index. It is instantiated once.

## Test plan
- Single reader: req1 writes 0xA0000001 to addr 5, then reads addr 5 → reqReady[1] both cycles; rspValid[1] one cycle after the read; rspData = 0xA0000001.
- All four requesters valid from reset, one-beat build → grant order 0,1,2,3,0; each reqReady pulse lasts one cycle.
- Burst build, MAXBURST=4, req0 and req2 held valid → grants 0,0,0,0,2,2,2,2,0…
- Burst build, req0 drops reqValid after 2 beats while req3 waits → the grant moves to 3 the next cycle.
- Back-to-back reads by req2 of addr 20..23 (preloaded 0xB0000014+k) → rspValid[2] on four consecutive cycles with matching data; rspValid for other requesters stays 0.
- Read accepted, then rst asserted before the response cycle → rspValid stays 0, ramEn=0 during reset, and the first grant after reset goes to requester 0.
